mem_arbiter: RTL and testbench

Shares one single-ported unified memory between the fetch stage (instruction port) and the mem stage (data port).
- One outstanding memory transaction at a time.
- Data port has priority, with a starvation guard for fetch.
- On a committed taken branch, an in-flight instruction read is squashed.
- Sits between the fetch/mem stages and the memory model.

---
 rtl/tartaruga_pkg.sv | 40 ++++
 rtl/arb_prio_sel.sv | 40 ++++
 rtl/mem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tartaruga_pkg.sv
// -----------------------------------------------------------------------------
// tartaruga_pkg
// Shared types for the instruction/data memory arbiter.
//   arb_state_e : arbiter FSM states
//   arb_owner_e : which port wins (or owns) a memory transaction
//   mem_req_t   : memory request fields, sized to the widest supported bus so
//                 the arbiter can carry them for any ADDR_WIDTH/DATA_WIDTH <= 64
// Helper function streak_width() sizes the fetch starvation counter.
// -----------------------------------------------------------------------------
package tartaruga_pkg;

  localparam int MEM_MAX_AW = 64;
  localparam int MEM_MAX_DW = 64;
  localparam int MEM_MAX_BE = MEM_MAX_DW / 8;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    BUSY_IF      = 2'd1,
    BUSY_DM      = 2'd2,
    BUSY_IF_KILL = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_DM = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic                  we;
    logic [MEM_MAX_AW-1:0] addr;
    logic [MEM_MAX_DW-1:0] wdata;
    logic [MEM_MAX_BE-1:0] be;
  } mem_req_t;

  // Counter width able to hold the value 'limit' itself.
  function automatic int streak_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/arb_prio_sel.sv
// -----------------------------------------------------------------------------
// arb_prio_sel
// Purely combinational winner pick between fetch and data requests.
// Data wins by default; fetch wins when data is absent, or when fetch has
// waited through STARVE_LIMIT consecutive data grants. A flush removes fetch
// from the contest for that cycle.
// Ports:
//   i_if_req  : fetch request level
//   i_dm_req  : data request level
//   i_flush   : taken-branch commit pulse, blocks a fetch grant
//   i_streak  : consecutive data grants while fetch waited
//   o_grant   : some port wins this cycle
//   o_owner   : winning port (valid when o_grant = 1)
// -----------------------------------------------------------------------------
module arb_prio_sel
  import tartaruga_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int STREAK_W     = 3
) (
  input  logic                i_if_req,
  input  logic                i_dm_req,
  input  logic                i_flush,
  input  logic [STREAK_W-1:0] i_streak,
  output logic                o_grant,
  output arb_owner_e          o_owner
);

  logic w_if_elig;
  logic w_force_if;

  assign w_if_elig  = i_if_req && !i_flush;
  assign w_force_if = w_if_elig && (i_streak == STREAK_W'(STARVE_LIMIT));

  always_comb begin
    o_grant = w_if_elig || i_dm_req;
    o_owner = (w_if_elig && (!i_dm_req || w_force_if)) ? OWNER_IF : OWNER_DM;
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-ported memory between the fetch (instruction) port and the
// mem-stage (data) port, one outstanding transaction at a time. Data has
// priority with a starvation guard for fetch; a committed taken branch
// (flush_i) squashes an in-flight fetch read.
//
// Optional build macro: ARB_PERF_COUNTERS_EN adds perf_if_grants_o,
// perf_dm_grants_o and perf_if_wait_o (32-bit wrapping event counters).
//
// Ports:
//   clk_i, rstn_i            : clock, asynchronous active-low reset
//   flush_i                  : taken-branch commit, kills fetch traffic
//   if_req_i/if_addr_i       : fetch read request (level-held)
//   if_gnt_o/if_rvalid_o/if_rdata_o : fetch grant and response
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i/dm_be_i : data request (level-held)
//   dm_gnt_o/dm_rvalid_o/dm_rdata_o : data grant and response (rdata 0 on store)
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_be_o : memory request
//   mem_rvalid_i/mem_rdata_i : memory response, latency >= 1 cycle
// -----------------------------------------------------------------------------
module mem_arbiter
  import tartaruga_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    flush_i,
  input  logic                    if_req_i,
  input  logic [ADDR_WIDTH-1:0]   if_addr_i,
  output logic                    if_gnt_o,
  output logic                    if_rvalid_o,
  output logic [DATA_WIDTH-1:0]   if_rdata_o,
  input  logic                    dm_req_i,
  input  logic                    dm_we_i,
  input  logic [ADDR_WIDTH-1:0]   dm_addr_i,
  input  logic [DATA_WIDTH-1:0]   dm_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] dm_be_i,
  output logic                    dm_gnt_o,
  output logic                    dm_rvalid_o,
  output logic [DATA_WIDTH-1:0]   dm_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic                    mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
`ifdef ARB_PERF_COUNTERS_EN
  ,
  output logic [31:0]             perf_if_grants_o,
  output logic [31:0]             perf_dm_grants_o,
  output logic [31:0]             perf_if_wait_o
`endif
);

  localparam int BE_W     = DATA_WIDTH / 8;
  localparam int STREAK_W = streak_width(STARVE_LIMIT);

  arb_state_e          r_state;
  logic                r_dm_we;
  logic [STREAK_W-1:0] r_streak;

  logic       w_idle;
  logic       w_pick;
  arb_owner_e w_owner;
  logic       w_if_gnt;
  logic       w_dm_gnt;
  mem_req_t   w_sel;
  logic       w_unused_sel;

  // Grants are combinational from the held request levels; they are also
  // masked by rstn_i so every output is 0 while reset is asserted.
  assign w_idle = (r_state == IDLE) && rstn_i;

  arb_prio_sel #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .STREAK_W     (STREAK_W)
  ) u_prio_sel (
    .i_if_req (if_req_i),
    .i_dm_req (dm_req_i),
    .i_flush  (flush_i),
    .i_streak (r_streak),
    .o_grant  (w_pick),
    .o_owner  (w_owner)
  );

  assign w_if_gnt = w_idle && w_pick && (w_owner == OWNER_IF);
  assign w_dm_gnt = w_idle && w_pick && (w_owner == OWNER_DM);

  // Memory request fields follow the winner; reads drive all byte enables.
  always_comb begin
    w_sel = '0;
    if (w_if_gnt) begin
      w_sel.addr             = MEM_MAX_AW'(if_addr_i);
      w_sel.be[BE_W-1:0]     = '1;
    end else if (w_dm_gnt) begin
      w_sel.we   = dm_we_i;
      w_sel.addr = MEM_MAX_AW'(dm_addr_i);
      if (dm_we_i) begin
        w_sel.wdata = MEM_MAX_DW'(dm_wdata_i);
        w_sel.be    = MEM_MAX_BE'(dm_be_i);
      end else begin
        w_sel.be[BE_W-1:0] = '1;
      end
    end
  end

  // Bits above the configured widths are always zero.
  assign w_unused_sel = ^w_sel;

  assign if_gnt_o    = w_if_gnt;
  assign dm_gnt_o    = w_dm_gnt;
  assign mem_req_o   = w_if_gnt || w_dm_gnt;
  assign mem_we_o    = w_sel.we;
  assign mem_addr_o  = w_sel.addr[ADDR_WIDTH-1:0];
  assign mem_wdata_o = w_sel.wdata[DATA_WIDTH-1:0];
  assign mem_be_o    = w_sel.be[BE_W-1:0];

  // Responses pass straight through in the cycle mem_rvalid_i arrives, so the
  // next grant can happen one cycle later. A flush coinciding with a fetch
  // response drops it.
  assign if_rvalid_o = (r_state == BUSY_IF) && mem_rvalid_i && !flush_i;
  assign dm_rvalid_o = (r_state == BUSY_DM) && mem_rvalid_i;
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
  assign dm_rdata_o  = (dm_rvalid_o && !r_dm_we) ? mem_rdata_i : '0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state  <= IDLE;
      r_dm_we  <= 1'b0;
      r_streak <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_if_gnt) begin
            r_state  <= BUSY_IF;
            r_streak <= '0;
          end else if (w_dm_gnt) begin
            r_state <= BUSY_DM;
            r_dm_we <= dm_we_i;
            // Only grants that made a waiting fetch wait extend the streak.
            if (!if_req_i) begin
              r_streak <= '0;
            end else if (r_streak != STREAK_W'(STARVE_LIMIT)) begin
              r_streak <= r_streak + STREAK_W'(1);
            end
          end
        end
        BUSY_IF: begin
          if (mem_rvalid_i) begin
            r_state <= IDLE;
          end else if (flush_i) begin
            r_state <= BUSY_IF_KILL;
          end
        end
        BUSY_DM: begin
          if (mem_rvalid_i) begin
            r_state <= IDLE;
          end
        end
        BUSY_IF_KILL: begin
          if (mem_rvalid_i) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_COUNTERS_EN
  logic [31:0] r_perf_if_grants;
  logic [31:0] r_perf_dm_grants;
  logic [31:0] r_perf_if_wait;

  // Killed fetches were still granted, so they count here.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_perf_if_grants <= '0;
      r_perf_dm_grants <= '0;
      r_perf_if_wait   <= '0;
    end else begin
      if (w_if_gnt) begin
        r_perf_if_grants <= r_perf_if_grants + 32'd1;
      end
      if (w_dm_gnt) begin
        r_perf_dm_grants <= r_perf_dm_grants + 32'd1;
      end
      if (if_req_i && !w_if_gnt) begin
        r_perf_if_wait <= r_perf_if_wait + 32'd1;
      end
    end
  end

  assign perf_if_grants_o = r_perf_if_grants;
  assign perf_dm_grants_o = r_perf_dm_grants;
  assign perf_if_wait_o   = r_perf_if_wait;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        flush_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [3:0]  dm_be_i;
  logic        dm_gnt_o;
  logic        dm_rvalid_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
`ifdef ARB_PERF_COUNTERS_EN
  logic [31:0] perf_if_grants_o;
  logic [31:0] perf_dm_grants_o;
  logic [31:0] perf_if_wait_o;
`endif

  always #5 clk_i = ~clk_i;

  mem_arbiter #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .flush_i      (flush_i),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_gnt_o     (if_gnt_o),
    .if_rvalid_o  (if_rvalid_o),
    .if_rdata_o   (if_rdata_o),
    .dm_req_i     (dm_req_i),
    .dm_we_i      (dm_we_i),
    .dm_addr_i    (dm_addr_i),
    .dm_wdata_i   (dm_wdata_i),
    .dm_be_i      (dm_be_i),
    .dm_gnt_o     (dm_gnt_o),
    .dm_rvalid_o  (dm_rvalid_o),
    .dm_rdata_o   (dm_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_be_o     (mem_be_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
`ifdef ARB_PERF_COUNTERS_EN
    ,
    .perf_if_grants_o (perf_if_grants_o),
    .perf_dm_grants_o (perf_dm_grants_o),
    .perf_if_wait_o   (perf_if_wait_o)
`endif
  );

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int    lat     = 1;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_stray  = 0;
  string glog     = "";

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t if_q[$];
  exp_t dm_q[$];

  // Directed vectors; memory answers every read with {addr[15:0], 16'hBEEF}.
  logic [31:0] pri_dm_addr [9] = '{32'h1000, 32'h1004, 32'h1008, 32'h100C, 32'h1010,
                                   32'h1014, 32'h1018, 32'h101C, 32'h1020};
  logic [31:0] pri_dm_exp  [9] = '{32'h1000BEEF, 32'h1004BEEF, 32'h1008BEEF, 32'h100CBEEF,
                                   32'h1010BEEF, 32'h1014BEEF, 32'h1018BEEF, 32'h101CBEEF,
                                   32'h1020BEEF};
  logic [31:0] pri_if_addr [2] = '{32'h200, 32'h204};
  logic [31:0] pri_if_exp  [2] = '{32'h0200BEEF, 32'h0204BEEF};
  logic [31:0] pf_if_addr  [8] = '{32'h600, 32'h604, 32'h608, 32'h60C,
                                   32'h800, 32'h804, 32'h808, 32'h80C};
  logic [31:0] pf_if_exp   [8] = '{32'h0600BEEF, 32'h0604BEEF, 32'h0608BEEF, 32'h060CBEEF,
                                   32'h0800BEEF, 32'h0804BEEF, 32'h0808BEEF, 32'h080CBEEF};
  logic [31:0] pf_dm_addr  [6] = '{32'h700, 32'h704, 32'h708, 32'h70C, 32'h710, 32'h714};
  logic [31:0] pf_dm_exp   [6] = '{32'h0700BEEF, 32'h0704BEEF, 32'h0708BEEF,
                                   32'h070CBEEF, 32'h0710BEEF, 32'h0714BEEF};

  function automatic void check32(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endfunction

  function automatic void check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endfunction

  task automatic check_outputs_zero(input string name);
    check32({name, "_ctl"}, {26'd0, if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o,
                             mem_req_o, mem_we_o}, 32'd0);
    check32({name, "_if_rdata"}, if_rdata_o, 32'd0);
    check32({name, "_dm_rdata"}, dm_rdata_o, 32'd0);
    check32({name, "_mem_addr"}, mem_addr_o, 32'd0);
    check32({name, "_mem_wdata_be"}, mem_wdata_o | {28'd0, mem_be_o}, 32'd0);
  endtask

  // Memory model: captures a request at the negedge of its grant cycle and
  // answers 'lat' cycles later. It ignores reset so stale answers can occur.
  logic        mem_pend = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_paddr = '0;

  initial begin
    forever begin
      @(negedge clk_i);
      if (mem_req_o) begin
        mem_pend  = 1'b1;
        mem_cnt   = lat;
        mem_paddr = mem_addr_o;
      end
    end
  end

  initial begin
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    forever begin
      @(posedge clk_i);
      #1;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      if (mem_pend) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = {mem_paddr[15:0], 16'hBEEF};
          mem_pend     = 1'b0;
        end
      end
    end
  end

  // Monitor: every response pulse is matched against the scoreboard.
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clk_i);
      if (if_rvalid_o) begin
        if (if_q.size() == 0) begin
          n_stray++; n_checks++; n_fail++;
          $display("FAIL if_rvalid_stray: got pulse with data %h at cycle %0d, required no pulse",
                   if_rdata_o, cyc);
        end else begin
          mon_e = if_q.pop_front();
          check32("if_rdata", if_rdata_o, mon_e.data);
          check_int("if_rvalid_cycle", cyc, mon_e.cyc);
          $display("IF  resp data=%h cycle=%0d", if_rdata_o, cyc);
        end
      end
      if (dm_rvalid_o) begin
        if (dm_q.size() == 0) begin
          n_stray++; n_checks++; n_fail++;
          $display("FAIL dm_rvalid_stray: got pulse with data %h at cycle %0d, required no pulse",
                   dm_rdata_o, cyc);
        end else begin
          mon_e = dm_q.pop_front();
          check32("dm_rdata", dm_rdata_o, mon_e.data);
          check_int("dm_rvalid_cycle", cyc, mon_e.cyc);
          $display("DM  resp data=%h cycle=%0d", dm_rdata_o, cyc);
        end
      end
    end
  end

  // Drivers are called at posedge+1; they hold the request until granted.
  task automatic do_if(input logic [31:0] a, input logic [31:0] exp, input bit push,
                       output int gc);
    exp_t e;
    gc = -1;
    if_req_i  = 1'b1;
    if_addr_i = a;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_i);
      if (if_gnt_o) begin
        gc = cyc;
        break;
      end
    end
    if (gc < 0) begin
      n_checks++; n_fail++;
      $display("FAIL if_grant_timeout: addr %h got no grant, required grant within 100 cycles", a);
    end else begin
      glog = {glog, "I"};
      check32("if_mem_addr", mem_addr_o, a);
      check32("if_mem_req_we_be", {26'd0, mem_req_o, mem_we_o, mem_be_o},
              {26'd0, 1'b1, 1'b0, 4'hF});
      if (push) begin
        e.data = exp;
        e.cyc  = gc + lat;
        if_q.push_back(e);
      end
      $display("IF  grant addr=%h cycle=%0d", a, gc);
    end
    @(posedge clk_i);
    #1;
    if_req_i = 1'b0;
  endtask

  task automatic do_dm(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] exp, input bit push,
                       output int gc);
    exp_t e;
    gc = -1;
    dm_req_i   = 1'b1;
    dm_we_i    = we;
    dm_addr_i  = a;
    dm_wdata_i = wd;
    dm_be_i    = be;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_i);
      if (dm_gnt_o) begin
        gc = cyc;
        break;
      end
    end
    if (gc < 0) begin
      n_checks++; n_fail++;
      $display("FAIL dm_grant_timeout: addr %h got no grant, required grant within 100 cycles", a);
    end else begin
      glog = {glog, "D"};
      check32("dm_mem_addr", mem_addr_o, a);
      check32("dm_mem_req_we_be", {26'd0, mem_req_o, mem_we_o, mem_be_o},
              {26'd0, 1'b1, we, (we ? be : 4'hF)});
      if (we) check32("dm_mem_wdata", mem_wdata_o, wd);
      if (push) begin
        e.data = exp;
        e.cyc  = gc + lat;
        dm_q.push_back(e);
      end
      $display("DM  grant we=%0b addr=%h cycle=%0d", we, a, gc);
    end
    @(posedge clk_i);
    #1;
    dm_req_i = 1'b0;
    dm_we_i  = 1'b0;
  endtask

  task automatic drain();
    repeat (8) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1, "watchdog");
  end

  int g0, g1, gd_a, gd_b, gi_a, gs, s0;

  initial begin
    rstn_i     = 1'b0;
    flush_i    = 1'b0;
    if_req_i   = 1'b1;
    if_addr_i  = 32'h40;
    dm_req_i   = 1'b1;
    dm_we_i    = 1'b1;
    dm_addr_i  = 32'h44;
    dm_wdata_i = 32'h12345678;
    dm_be_i    = 4'hF;

    // Reset state: outputs stay 0 even with both requests high.
    @(negedge clk_i);
    check_outputs_zero("reset_held");
    if_req_i = 1'b0;
    dm_req_i = 1'b0;
    dm_we_i  = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    check_outputs_zero("after_release");
`ifdef ARB_PERF_COUNTERS_EN
    check32("perf_reset", perf_if_grants_o | perf_dm_grants_o | perf_if_wait_o, 32'd0);
`endif
    @(posedge clk_i);
    #1;

    // Single fetch, latency 2, then a back-to-back fetch.
    lat = 2;
    do_if(32'h100, 32'h0100BEEF, 1'b1, g0);
    do_if(32'h104, 32'h0104BEEF, 1'b1, g1);
    check_int("if_back_to_back_gap", g1 - g0, 3);
    drain();

    // Both ports contending, latency 1: starvation guard every 4 data grants.
    lat  = 1;
    glog = "";
    fork
      begin
        for (int i = 0; i < 2; i++) do_if(pri_if_addr[i], pri_if_exp[i], 1'b1, gi_a);
      end
      begin
        for (int j = 0; j < 9; j++)
          do_dm(1'b0, pri_dm_addr[j], 32'd0, 4'hF, pri_dm_exp[j], 1'b1, gd_a);
      end
    join
    n_checks++;
    if (glog != "DDDDIDDDDID") begin
      n_fail++;
      $display("FAIL grant_order: got %s, required DDDDIDDDDID", glog);
    end
    drain();

    // Partial store then a load: byte enables and store ack data.
    lat = 2;
    do_dm(1'b1, 32'h2000, 32'hCAFEF00D, 4'b0011, 32'd0, 1'b1, gd_a);
    do_dm(1'b0, 32'h2004, 32'd0, 4'b0011, 32'h2004BEEF, 1'b1, gd_b);
    drain();

    // Flush one cycle after a fetch grant, latency 3; waiting data follows.
    lat = 3;
    do_if(32'h300, 32'd0, 1'b0, g0);
    flush_i = 1'b1;
    fork
      begin
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
      end
    join_none
    do_dm(1'b0, 32'h400, 32'd0, 4'hF, 32'h0400BEEF, 1'b1, g1);
    check_int("dm_grant_after_kill", g1 - g0, 4);
    drain();

    // Reset while a load is outstanding; its late answer must be ignored.
    lat = 5;
    do_dm(1'b0, 32'h500, 32'd0, 4'hF, 32'd0, 1'b0, gd_a);
    rstn_i   = 1'b0;
    if_req_i = 1'b1;
    dm_req_i = 1'b1;
    #1;
    check_outputs_zero("reset_mid_busy");
    @(negedge clk_i);
    if_req_i = 1'b0;
    dm_req_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    s0 = n_stray;
    repeat (8) @(posedge clk_i);
    #1;
    check_int("stale_rvalid_ignored", n_stray - s0, 0);

    // Counter scenario from a fresh reset: 10 fetches, 6 data ops.
    @(negedge clk_i);
    rstn_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(posedge clk_i);
    #1;
    lat = 1;
    fork
      begin
        for (int i = 0; i < 4; i++) do_if(pf_if_addr[i], pf_if_exp[i], 1'b1, gi_a);
      end
      begin
        for (int j = 0; j < 6; j++)
          do_dm(1'b0, pf_dm_addr[j], 32'd0, 4'hF, pf_dm_exp[j], 1'b1, gd_b);
      end
    join
    repeat (3) @(posedge clk_i);
    #1;
    for (int i = 4; i < 8; i++) begin
      do_if(pf_if_addr[i], pf_if_exp[i], 1'b1, gi_a);
      repeat (3) @(posedge clk_i);
      #1;
    end
    // Killed fetch: flush lands together with the memory response.
    do_if(32'h810, 32'd0, 1'b0, gi_a);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    // Flush in IDLE holds off a fetch grant for that cycle.
    gs      = cyc;
    flush_i = 1'b1;
    fork
      begin
        @(posedge clk_i);
        #1;
        flush_i = 1'b0;
      end
    join_none
    do_if(32'h814, 32'h0814BEEF, 1'b1, gi_a);
    check_int("if_gnt_blocked_by_flush", gi_a - gs, 1);
    drain();
`ifdef ARB_PERF_COUNTERS_EN
    check32("perf_if_grants", perf_if_grants_o, 32'd10);
    check32("perf_dm_grants", perf_dm_grants_o, 32'd6);
    check32("perf_if_wait", perf_if_wait_o, 32'd16);
`endif

    check_int("if_scoreboard_empty", if_q.size(), 0);
    check_int("dm_scoreboard_empty", dm_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
